sqrt_unit: RTL

SQRT_UNIT -- requirements
Module: sqrt_unit

---
 rtl/sqrt_unit_if.sv | 39 +++
 rtl/sqrt_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sqrt_unit_if.sv
// sqrt_unit_if: radicand-in / root-out valid-ready bundle.
// slave = square-root unit side, master = producer/consumer side.
interface sqrt_unit_if #(
  parameter int TOTAL_WIDTH    = 16,
  parameter int FRACTION_WIDTH = 0
);
  localparam int RW = (TOTAL_WIDTH + FRACTION_WIDTH) / 2;

  logic                   i_valid;
  logic                   o_ready;
  logic [TOTAL_WIDTH-1:0] i_rad;
  logic                   o_valid;
  logic                   i_ready;
  logic [TOTAL_WIDTH-1:0] o_root;
  logic [RW:0]            o_rem;
  logic                   o_busy;

  modport slave (
    input  i_valid,
    input  i_rad,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_root,
    output o_rem,
    output o_busy
  );

  modport master (
    output i_valid,
    output i_rad,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_root,
    input  o_rem,
    input  o_busy
  );
endinterface

// File: rtl/sqrt_unit.sv
// sqrt_unit: iterative restoring square root, STEPS_PER_CYCLE root bits/clk.
// Ports: i_clk, i_rst (async, active high), bus (sqrt_unit_if.slave):
//   i_valid/o_ready/i_rad in, o_valid/i_ready/o_root/o_rem/o_busy out.
// Macro SQRT_UNIT_ROUND_EN: round o_root to nearest (saturating).
module sqrt_unit #(
  parameter int TOTAL_WIDTH     = 16,
  parameter int FRACTION_WIDTH  = 0,
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic         i_clk,
  input logic         i_rst,
  sqrt_unit_if.slave  bus
);
  localparam int RW = (TOTAL_WIDTH + FRACTION_WIDTH) / 2;
  localparam int XW = 2 * RW;
  localparam int N  = RW / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [RW-1:0] q_q, q_d;
  logic [RW:0]   r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ready;
  logic          accept;

  logic [XW-1:0] xs;
  logic [RW-1:0] qs;
  logic [RW:0]   rs;
  logic [RW+1:0] sh;
  logic [RW+1:0] trial;

  assign ready = (state_q == IDLE) ||
                 ((state_q == DONE) && bus.i_ready);
  assign accept = bus.i_valid && ready;

  // Unrolled restoring steps; the remainder never exceeds 2q, so
  // RW bits of it plus two radicand bits fit the RW+2 accumulator
  // and the trial's top bit is its sign.
  always_comb begin
    xs    = x_q;
    qs    = q_q;
    rs    = r_q;
    sh    = '0;
    trial = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      sh    = {rs[RW-1:0], xs[XW-1 -: 2]};
      trial = sh - {qs, 2'b01};
      xs    = xs << 2;
      if (trial[RW+1]) begin
        rs = sh[RW:0];
        qs = {qs[RW-2:0], 1'b0};
      end else begin
        rs = trial[RW:0];
        qs = {qs[RW-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          x_d     = XW'(bus.i_rad) << FRACTION_WIDTH;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CW'(N);
        end
      end
      CALC: begin
        x_d   = xs;
        q_d   = qs;
        r_d   = rs;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_d = CALC;
          x_d     = XW'(bus.i_rad) << FRACTION_WIDTH;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CW'(N);
        end else if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [RW-1:0] q_out;

`ifdef SQRT_UNIT_ROUND_EN
  // Round up when the remainder passes q (fraction >= .5);
  // an all-ones root has nowhere to go and stays put.
  always_comb begin
    q_out = q_q;
    if ((r_q > {1'b0, q_q}) && !(&q_q)) begin
      q_out = q_q + 1'b1;
    end
  end
`else
  assign q_out = q_q;
`endif

  assign bus.o_ready = ready;
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_busy  = (state_q == CALC);
  assign bus.o_root  = TOTAL_WIDTH'(q_out);
  assign bus.o_rem   = r_q;

endmodule
